// File: rtl/count_sequence_monitor.sv
// Checks that a sampled WIDTH-bit counter advances by exactly +1 (modulo 2**WIDTH), locks after
// SYNC_LEN good steps, and records every mismatch seen while locked for on-board debug.
module count_sequence_monitor #(
  parameter int WIDTH     = 4,
  parameter int SYNC_LEN  = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic                 en,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     count_in,
  output logic                 locked,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_got,
  output logic [1:0]           state
);

  localparam int SC_W = $clog2(SYNC_LEN + 1);
  localparam logic [SC_W-1:0] SYNC_LAST = SC_W'(SYNC_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    TRACK = 2'b10
  } state_t;

  state_t               r_state;
  logic [SC_W-1:0]      r_sync_cnt;
  logic [WIDTH-1:0]     r_prev;
  logic                 r_locked;
  logic                 r_err;
  logic                 r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [WIDTH-1:0]     r_first_exp;
  logic [WIDTH-1:0]     r_first_got;

  logic [WIDTH-1:0]     w_exp;
  logic                 w_match;
  logic                 w_track_err;
  logic                 w_sticky_base;
  logic [ERR_CNT_W-1:0] w_cnt_base;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Expected value, match decision and status values with a coincident clear already applied
  always_comb begin
    w_exp         = r_prev + {{(WIDTH-1){1'b0}}, 1'b1};
    w_match       = (count_in == w_exp);
    w_track_err   = en & (r_state == TRACK) & ~w_match;
    w_sticky_base = clear ? 1'b0 : r_err_sticky;
    w_cnt_base    = clear ? {ERR_CNT_W{1'b0}} : r_err_count;
  end

  // Lock FSM, previous-sample register and one-cycle error pulse
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= IDLE;
      r_sync_cnt <= {SC_W{1'b0}};
      r_prev     <= {WIDTH{1'b0}};
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_track_err;
      case (r_state)
        IDLE: begin
          if (en) begin
            r_state    <= SYNC;
            r_sync_cnt <= {SC_W{1'b0}};
          end
        end
        SYNC: begin
          if (en) begin
            if (w_match && (r_sync_cnt == SYNC_LAST)) begin
              r_state    <= TRACK;
              r_locked   <= 1'b1;
              r_sync_cnt <= {SC_W{1'b0}};
            end else if (w_match) begin
              r_sync_cnt <= r_sync_cnt + SC_W'(1);
            end else begin
              r_sync_cnt <= {SC_W{1'b0}};
            end
          end
        end
        TRACK: begin
          if (w_track_err) begin
            r_state    <= SYNC;
            r_locked   <= 1'b0;
            r_sync_cnt <= {SC_W{1'b0}};
          end
        end
        default: begin
          r_state    <= IDLE;
          r_locked   <= 1'b0;
          r_sync_cnt <= {SC_W{1'b0}};
        end
      endcase
      if (en) begin
        r_prev <= count_in;
      end
    end
  end

  // Debug status: a coincident clear wipes history before the new error is logged
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= {ERR_CNT_W{1'b0}};
      r_first_exp  <= {WIDTH{1'b0}};
      r_first_got  <= {WIDTH{1'b0}};
    end else if (w_track_err) begin
      r_err_sticky <= 1'b1;
      r_err_count  <= sat_inc(w_cnt_base);
      if (!w_sticky_base) begin
        r_first_exp <= w_exp;
        r_first_got <= count_in;
      end
    end else if (clear) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= {ERR_CNT_W{1'b0}};
      r_first_exp  <= {WIDTH{1'b0}};
      r_first_got  <= {WIDTH{1'b0}};
    end
  end

  assign locked     = r_locked;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;
  assign first_exp  = r_first_exp;
  assign first_got  = r_first_got;
  assign state      = r_state;

endmodule
